mem_ctrl: RTL and testbench

Memory controller that serves as the responder for the load/store buffer's memory request port and the instruction-fetch port, serialising each request onto the byte-wide RAM bus. It accepts one request at a time and arbitrates LSB over fetch. It performs 1/2/4-byte loads (sign- or zero-extended) and stores, plus 4-byte instruction fetches, and returns a one-cycle completion pulse to the requester. Uncommitted work (loads, fetches) is discarded on rollback; stores always complete.

---
 rtl/mem_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_mem_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: LSB loads/stores and instruction fetches onto a byte-wide RAM bus.
// LSB requests win arbitration; loads and fetches are dropped on rollback, stores always finish.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback_config,
  input  logic        lsb_in_config,
  input  logic        lsb_in_ls,
  input  logic [31:0] lsb_in_addr,
  input  logic [31:0] lsb_in_data,
  input  logic [2:0]  lsb_in_precise,
  input  logic [3:0]  lsb_in_rob,
  output logic        lsb_out_config,
  output logic [31:0] lsb_out_data,
  input  logic        if_in_config,
  input  logic [31:0] if_in_addr,
  output logic        if_out_config,
  output logic [31:0] if_out_data,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);
  typedef enum logic [2:0] {IDLE, LOAD, STORE, FETCH, COOL} state_t;

  state_t      state, state_next;
  logic [2:0]  cnt;
  logic [2:0]  cnt_nxt;
  logic        wr_pend;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [31:0] rd_buf;
  logic [31:0] rd_word;
  logic [2:0]  req_n;
  logic        req_uns;
  logic        accept_lsb;
  logic        accept_if;
  logic        finish;
  logic        io_stall;
  logic        unused_rob;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'd0:    size_bytes = 3'd1;
      2'd1:    size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] n,
                                         input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = w[7:0];
    h = w[15:0];
    case (n)
      3'd1:    extend = uns ? {24'd0, w[7:0]} : 32'(b);
      3'd2:    extend = uns ? {16'd0, w[15:0]} : 32'(h);
      default: extend = w;
    endcase
  endfunction

  assign cnt_nxt    = cnt + 3'd1;
  assign io_stall   = (req_addr[17:16] == 2'b11) && io_buffer_full;
  assign mem_wr     = wr_pend & rdy;
  assign unused_rob = ^lsb_in_rob;

  // Byte cnt-1 arrives on mem_din one cycle after its address was presented.
  always_comb begin
    rd_word = rd_buf;
    rd_word[{cnt[1:0] - 2'd1, 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    state_next = state;
    accept_lsb = 1'b0;
    accept_if  = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (lsb_in_config) begin
          accept_lsb = 1'b1;
          state_next = lsb_in_ls ? LOAD : STORE;
        end else if (if_in_config && !rollback_config) begin
          accept_if  = 1'b1;
          state_next = FETCH;
        end
      end
      LOAD, FETCH: begin
        if (rollback_config) begin
          state_next = IDLE;
        end else if (cnt == req_n) begin
          finish     = 1'b1;
          state_next = COOL;
        end
      end
      STORE: begin
        if (wr_pend && cnt == req_n - 3'd1) begin
          finish     = 1'b1;
          state_next = COOL;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      wr_pend        <= 1'b0;
      mem_a          <= '0;
      mem_dout       <= '0;
      lsb_out_config <= 1'b0;
      lsb_out_data   <= '0;
      if_out_config  <= 1'b0;
      if_out_data    <= '0;
    end else if (rdy) begin
      state          <= state_next;
      lsb_out_config <= 1'b0;
      if_out_config  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_lsb || accept_if) begin
            cnt      <= '0;
            mem_a    <= accept_lsb ? lsb_in_addr : if_in_addr;
            mem_dout <= lsb_in_data[7:0];
            wr_pend  <= accept_lsb && !lsb_in_ls &&
                        !(lsb_in_addr[17:16] == 2'b11 && io_buffer_full);
          end
        end
        LOAD, FETCH: begin
          if (finish) begin
            if (state == LOAD) begin
              lsb_out_config <= 1'b1;
              lsb_out_data   <= extend(rd_word, req_n, req_uns);
            end else begin
              if_out_config <= 1'b1;
              if_out_data   <= rd_word;
            end
          end else if (!rollback_config) begin
            cnt <= cnt_nxt;
            if (cnt_nxt < req_n) mem_a <= req_addr + 32'(cnt_nxt);
          end
        end
        STORE: begin
          if (finish) begin
            wr_pend        <= 1'b0;
            lsb_out_config <= 1'b1;
          end else if (wr_pend) begin
            cnt      <= cnt_nxt;
            mem_a    <= req_addr + 32'(cnt_nxt);
            mem_dout <= req_data[{cnt_nxt[1:0], 3'b000} +: 8];
            wr_pend  <= !io_stall;
          end else begin
            wr_pend <= !io_stall;
          end
        end
        default: ;
      endcase
    end
  end

  // Request payload and read assembly buffer carry no reset.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (state == IDLE) begin
        req_addr <= accept_lsb ? lsb_in_addr : if_in_addr;
        req_data <= lsb_in_data;
        req_n    <= accept_lsb ? size_bytes(lsb_in_precise[1:0]) : 3'd4;
        req_uns  <= lsb_in_precise[2];
        rd_buf   <= '0;
      end else if ((state == LOAD || state == FETCH) && cnt != 3'd0) begin
        rd_buf <= rd_word;
      end
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte-addressed RAM model, directed scenarios and
// randomized loads/stores compared against a memory-image reference model.
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        rollback_config = 1'b0;
  logic        lsb_in_config = 1'b0;
  logic        lsb_in_ls = 1'b0;
  logic [31:0] lsb_in_addr = '0;
  logic [31:0] lsb_in_data = '0;
  logic [2:0]  lsb_in_precise = '0;
  logic [3:0]  lsb_in_rob = '0;
  logic        lsb_out_config;
  logic [31:0] lsb_out_data;
  logic        if_in_config = 1'b0;
  logic [31:0] if_in_addr = '0;
  logic        if_out_config;
  logic [31:0] if_out_data;
  logic [7:0]  mem_din = '0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0]  ram     [0:262143];
  logic [7:0]  exp_ram [0:262143];
  logic        ram_ready = 1'b0;
  logic        poke_en = 1'b0;
  logic [17:0] poke_a = '0;
  logic [7:0]  poke_d = '0;
  logic [39:0] wr_log [0:1023];
  int          wr_cnt = 0;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback_config(rollback_config),
    .lsb_in_config(lsb_in_config), .lsb_in_ls(lsb_in_ls), .lsb_in_addr(lsb_in_addr),
    .lsb_in_data(lsb_in_data), .lsb_in_precise(lsb_in_precise), .lsb_in_rob(lsb_in_rob),
    .lsb_out_config(lsb_out_config), .lsb_out_data(lsb_out_data),
    .if_in_config(if_in_config), .if_in_addr(if_in_addr),
    .if_out_config(if_out_config), .if_out_data(if_out_data),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37) ^ (i >> 7));
  endfunction

  // RAM: read data appears the cycle after the address; writes logged in order.
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 262144; i++) ram[i] = init_byte(i);
      ram_ready <= 1'b1;
    end
    mem_din <= ram[mem_a[17:0]];
    if (poke_en) ram[poke_a] <= poke_d;
    if (mem_wr) begin
      ram[mem_a[17:0]] <= mem_dout;
      if (wr_cnt < 1024) wr_log[wr_cnt] <= {mem_a, mem_dout};
      wr_cnt <= wr_cnt + 1;
    end
  end

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] p);
    longint v;
    int     n;
    v = 0;
    n = (p[1:0] == 2'd0) ? 1 : (p[1:0] == 2'd1) ? 2 : 4;
    for (int k = 0; k < n; k++) v += longint'(exp_ram[18'(a + 32'(k))]) << (8 * k);
    if (!p[2] && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_a = a[17:0]; poke_d = d;
    exp_ram[a[17:0]] = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Issues one LSB request and reports pulse latency (edges after acceptance), data,
  // whether the pulse lingered, and count of writes seen while frozen or IO-stalled.
  task automatic do_lsb(input logic ls, input logic [31:0] addr, input logic [31:0] data,
                        input logic [2:0] prec, input int rb_at, input int rdy_at,
                        input int io_cyc, output int lat, output logic [31:0] rdata,
                        output logic after, output int viol);
    lat = -1; rdata = '0; after = 1'b0; viol = 0;
    @(negedge clk);
    lsb_in_config = 1'b1; lsb_in_ls = ls; lsb_in_addr = addr; lsb_in_data = data;
    lsb_in_precise = prec; lsb_in_rob = 4'($urandom);
    io_buffer_full = (io_cyc > 0);
    for (int j = 1; j <= 30 && lat < 0; j++) begin
      @(negedge clk);
      if (mem_wr && (!rdy || io_buffer_full)) viol++;
      if (lsb_out_config) begin lat = j - 1; rdata = lsb_out_data; end
      if (j == io_cyc) io_buffer_full = 1'b0;
      if (rollback_config) rollback_config = 1'b0;
      if (j == rb_at) begin rollback_config = 1'b1; lsb_in_config = 1'b0; end
      if (j == rdy_at) rdy = 1'b0;
      if (j == rdy_at + 3) rdy = 1'b1;
    end
    lsb_in_config = 1'b0; rollback_config = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
    @(negedge clk);
    after = lsb_out_config;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({lsb_out_config, if_out_config, mem_wr, lsb_out_data, if_out_data, mem_a, mem_dout} !== '0)
      begin n_fail++; $display("FAIL reset_outputs: got %h required 0",
        {lsb_out_config, if_out_config, mem_wr, lsb_out_data, if_out_data, mem_a, mem_dout}); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({lsb_out_config, if_out_config, mem_wr} !== 3'b000)
      begin n_fail++; $display("FAIL idle_after_reset: got %b required 000",
        {lsb_out_config, if_out_config, mem_wr}); end
  endtask

  task automatic test_loads;
    int lat, viol; logic [31:0] rd; logic after;
    poke(32'h1000, 8'h78); poke(32'h1001, 8'h56); poke(32'h1002, 8'h34); poke(32'h1003, 8'h12);
    poke(32'h20, 8'h80); poke(32'h22, 8'hFE); poke(32'h23, 8'hFF);
    do_lsb(1'b1, 32'h1000, '0, 3'b010, 0, 0, 0, lat, rd, after, viol);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL lw_latency: got %0d required 5", lat); end
    n_checks++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL lw_data: got %h required 12345678", rd); end
    n_checks++; if (after !== 1'b0) begin n_fail++; $display("FAIL lw_pulse_width: second cycle %b required 0", after); end
    do_lsb(1'b1, 32'h20, '0, 3'b000, 0, 0, 0, lat, rd, after, viol);
    n_checks++; if (lat !== 2 || rd !== 32'hFFFFFF80)
      begin n_fail++; $display("FAIL lb_signed: got lat %0d data %h required 2 FFFFFF80", lat, rd); end
    do_lsb(1'b1, 32'h20, '0, 3'b100, 0, 0, 0, lat, rd, after, viol);
    n_checks++; if (lat !== 2 || rd !== 32'h00000080)
      begin n_fail++; $display("FAIL lbu: got lat %0d data %h required 2 00000080", lat, rd); end
    do_lsb(1'b1, 32'h22, '0, 3'b001, 0, 0, 0, lat, rd, after, viol);
    n_checks++; if (lat !== 3 || rd !== 32'hFFFFFFFE)
      begin n_fail++; $display("FAIL lh_signed: got lat %0d data %h required 3 FFFFFFFE", lat, rd); end
  endtask

  task automatic test_store;
    int lat, viol, w0; logic [31:0] rd; logic after;
    w0 = wr_cnt;
    do_lsb(1'b0, 32'h100, 32'h12345678, 3'b001, 0, 0, 0, lat, rd, after, viol);
    exp_ram[18'h100] = 8'h78; exp_ram[18'h101] = 8'h56;
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL sh_latency: got %0d required 2", lat); end
    n_checks++; if (wr_cnt - w0 !== 2) begin n_fail++; $display("FAIL sh_write_count: got %0d required 2", wr_cnt - w0); end
    n_checks++; if (wr_log[w0] !== {32'h100, 8'h78} || wr_log[w0 + 1] !== {32'h101, 8'h56})
      begin n_fail++; $display("FAIL sh_writes: got %h %h required 0000010078 0000010156", wr_log[w0], wr_log[w0 + 1]); end
    n_checks++; if (ram[18'h102] !== exp_ram[18'h102])
      begin n_fail++; $display("FAIL sh_untouched: got %h required %h", ram[18'h102], exp_ram[18'h102]); end
    n_checks++; if (mem_wr !== 1'b0 || after !== 1'b0)
      begin n_fail++; $display("FAIL sh_quiet_after: mem_wr %b pulse %b required 0 0", mem_wr, after); end
  endtask

  task automatic test_arbitration;
    int lsb_lat, if_lat, lsb_cnt, both; logic [31:0] ld, fd;
    poke(32'h40, 8'hEF); poke(32'h41, 8'hBE); poke(32'h42, 8'hAD); poke(32'h43, 8'hDE);
    poke(32'h80, 8'h13); poke(32'h81, 8'h05); poke(32'h82, 8'h10); poke(32'h83, 8'h00);
    lsb_lat = -1; if_lat = -1; lsb_cnt = 0; both = 0; ld = '0; fd = '0;
    @(negedge clk);
    lsb_in_config = 1'b1; lsb_in_ls = 1'b1; lsb_in_addr = 32'h40; lsb_in_precise = 3'b010;
    if_in_config = 1'b1; if_in_addr = 32'h80;
    for (int j = 1; j <= 40 && if_lat < 0; j++) begin
      @(negedge clk);
      if (lsb_out_config && if_out_config) both++;
      if (lsb_out_config) begin
        lsb_cnt++;
        if (lsb_lat < 0) begin lsb_lat = j - 1; ld = lsb_out_data; end
      end
      if (if_out_config) begin if_lat = j - 1; fd = if_out_data; end
      if (lsb_lat >= 0 && j == lsb_lat + 2) lsb_in_config = 1'b0;
      if (if_lat >= 0) if_in_config = 1'b0;
    end
    lsb_in_config = 1'b0; if_in_config = 1'b0;
    @(negedge clk);
    n_checks++; if (lsb_lat !== 5 || ld !== 32'hDEADBEEF)
      begin n_fail++; $display("FAIL arb_load_first: got lat %0d data %h required 5 DEADBEEF", lsb_lat, ld); end
    n_checks++; if (if_lat !== 12 || fd !== 32'h00100513)
      begin n_fail++; $display("FAIL arb_fetch: got lat %0d data %h required 12 00100513", if_lat, fd); end
    n_checks++; if (lsb_cnt !== 1 || both !== 0 || if_out_config !== 1'b0)
      begin n_fail++; $display("FAIL arb_single_pulses: lsb pulses %0d overlaps %0d required 1 0", lsb_cnt, both); end
  endtask

  task automatic test_rollback;
    int lat, viol, w0; logic [31:0] rd; logic after;
    w0 = wr_cnt;
    do_lsb(1'b1, 32'h1000, '0, 3'b010, 3, 0, 0, lat, rd, after, viol);
    n_checks++; if (lat !== -1 || wr_cnt !== w0)
      begin n_fail++; $display("FAIL rollback_lw: got lat %0d writes %0d required -1 0", lat, wr_cnt - w0); end
    do_lsb(1'b1, 32'h20, '0, 3'b100, 0, 0, 0, lat, rd, after, viol);
    n_checks++; if (lat !== 2 || rd !== 32'h80)
      begin n_fail++; $display("FAIL idle_after_rollback: got lat %0d data %h required 2 00000080", lat, rd); end
    w0 = wr_cnt;
    do_lsb(1'b0, 32'h180, 32'hCAFEF00D, 3'b010, 2, 0, 0, lat, rd, after, viol);
    exp_ram[18'h180] = 8'h0D; exp_ram[18'h181] = 8'hF0; exp_ram[18'h182] = 8'hFE; exp_ram[18'h183] = 8'hCA;
    n_checks++; if (lat !== 4 || wr_cnt - w0 !== 4)
      begin n_fail++; $display("FAIL rollback_sw: got lat %0d writes %0d required 4 4", lat, wr_cnt - w0); end
    n_checks++; if ({ram[18'h183], ram[18'h182], ram[18'h181], ram[18'h180]} !== 32'hCAFEF00D)
      begin n_fail++; $display("FAIL rollback_sw_data: got %h required CAFEF00D",
        {ram[18'h183], ram[18'h182], ram[18'h181], ram[18'h180]}); end
  endtask

  task automatic test_io_stall;
    int lat, viol, w0; logic [31:0] rd; logic after;
    w0 = wr_cnt;
    do_lsb(1'b0, 32'h30000, 32'h000000A5, 3'b000, 0, 0, 3, lat, rd, after, viol);
    exp_ram[18'h30000] = 8'hA5;
    n_checks++; if (lat !== 4 || viol !== 0)
      begin n_fail++; $display("FAIL io_stall: got lat %0d stalled writes %0d required 4 0", lat, viol); end
    n_checks++; if (wr_cnt - w0 !== 1 || ram[18'h30000] !== 8'hA5)
      begin n_fail++; $display("FAIL io_write: got writes %0d byte %h required 1 A5", wr_cnt - w0, ram[18'h30000]); end
  endtask

  task automatic test_rdy_freeze;
    int lat, viol, w0; logic [31:0] rd; logic after;
    w0 = wr_cnt;
    do_lsb(1'b0, 32'h300, 32'h89ABCDEF, 3'b010, 0, 2, 0, lat, rd, after, viol);
    exp_ram[18'h300] = 8'hEF; exp_ram[18'h301] = 8'hCD; exp_ram[18'h302] = 8'hAB; exp_ram[18'h303] = 8'h89;
    n_checks++; if (lat !== 7 || viol !== 0 || wr_cnt - w0 !== 4)
      begin n_fail++; $display("FAIL rdy_freeze: got lat %0d frozen writes %0d writes %0d required 7 0 4",
        lat, viol, wr_cnt - w0); end
    n_checks++; if ({ram[18'h303], ram[18'h302], ram[18'h301], ram[18'h300]} !== 32'h89ABCDEF)
      begin n_fail++; $display("FAIL rdy_freeze_data: got %h required 89ABCDEF",
        {ram[18'h303], ram[18'h302], ram[18'h301], ram[18'h300]}); end
  endtask

  task automatic test_async_reset;
    logic [31:0] old, data;
    old  = {exp_ram[18'h203], exp_ram[18'h202], exp_ram[18'h201], exp_ram[18'h200]};
    data = ~old;
    @(negedge clk);
    lsb_in_config = 1'b1; lsb_in_ls = 1'b0; lsb_in_addr = 32'h200; lsb_in_data = data;
    lsb_in_precise = 3'b010;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1; lsb_in_config = 1'b0;
    #1;
    n_checks++;
    if ({lsb_out_config, if_out_config, mem_wr, lsb_out_data, if_out_data, mem_a, mem_dout} !== '0)
      begin n_fail++; $display("FAIL async_reset: got %h required 0",
        {lsb_out_config, if_out_config, mem_wr, lsb_out_data, if_out_data, mem_a, mem_dout}); end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    exp_ram[18'h200] = data[7:0];
    n_checks++;
    if ({ram[18'h203], ram[18'h202], ram[18'h201], ram[18'h200]} !== {old[31:8], data[7:0]})
      begin n_fail++; $display("FAIL abandoned_store: got %h required %h",
        {ram[18'h203], ram[18'h202], ram[18'h201], ram[18'h200]}, {old[31:8], data[7:0]}); end
  endtask

  task automatic test_random;
    int lat, viol, w0, n; logic [31:0] rd, addr, data, expv; logic after, uns; logic [1:0] sz;
    for (int i = 0; i < 24; i++) begin
      sz = 2'($urandom_range(0, 2)); uns = 1'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, 32'h1FFF0)); data = $urandom;
      n = 1 << sz;
      if ($urandom_range(0, 1) == 1) begin
        expv = model_load(addr, {uns, sz});
        do_lsb(1'b1, addr, '0, {uns, sz}, 0, 0, 0, lat, rd, after, viol);
        n_checks++; if (lat !== n + 1 || rd !== expv)
          begin n_fail++; $display("FAIL rand_load %0d: addr %h got lat %0d data %h required %0d %h",
            i, addr, lat, rd, n + 1, expv); end
      end else begin
        w0 = wr_cnt;
        do_lsb(1'b0, addr, data, {uns, sz}, 0, 0, 0, lat, rd, after, viol);
        for (int k = 0; k < n; k++) exp_ram[18'(addr + 32'(k))] = data[8 * k +: 8];
        n_checks++; if (lat !== n || wr_cnt - w0 !== n)
          begin n_fail++; $display("FAIL rand_store %0d: got lat %0d writes %0d required %0d %0d",
            i, lat, wr_cnt - w0, n, n); end
        for (int k = 0; k <= n; k++) begin
          n_checks++;
          if (ram[18'(addr + 32'(k))] !== exp_ram[18'(addr + 32'(k))])
            begin n_fail++; $display("FAIL rand_store_byte %0d+%0d: got %h required %h", i, k,
              ram[18'(addr + 32'(k))], exp_ram[18'(addr + 32'(k))]); end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) exp_ram[i] = init_byte(i);
    test_reset;
    test_loads;
    test_store;
    test_arbitration;
    test_rollback;
    test_io_stall;
    test_rdy_freeze;
    test_async_reset;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
